display_timing_gen: RTL and testbench
=====================================

DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CORDW, 12: signed coordinate width
- H_RES, 1024: active pixels per line
- H_FP, 160: horizontal front porch, pixels
- H_SYNC, 20: horizontal sync width, pixels
- H_BP, 140: horizontal back porch, pixels
- V_RES, 600: active lines per frame
- V_FP, 12: vertical front porch, lines
- V_SYNC, 3: vertical sync width, lines
- V_BP, 20: vertical back porch, lines
- H_POL, 0: hsync active level
- V_POL, 0: vsync active level
- FCW, 8: frame counter width
REQ-002 Ports (name, direction, width, meaning):
- clk_pix, in, 1: pixel clock
- rst_n, in, 1: asynchronous active-low reset
- en, in, 1: advance enable; 0 freezes timing
- resync, in, 1: single-cycle request to restart at frame start
- sx, out, CORDW signed: horizontal position
- sy, out, CORDW signed: vertical position
- hsync, out, 1: horizontal sync, polarity H_POL
- vsync, out, 1: vertical sync, polarity V_POL
- de, out, 1: data enable, active video
- line, out, 1: one-cycle pulse at line start
- frame, out, 1: one-cycle pulse at frame start
- fcnt, out, FCW: frame counter
REQ-003 The block SHALL use one clock, clk_pix; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 Derived constants: H_STA = -(H_FP+H_SYNC+H_BP), H_END = H_RES-1, V_STA = -(V_FP+V_SYNC+V_BP), V_END = V_RES-1. Elaboration SHALL fail if H_STA or V_STA is not representable in CORDW signed bits.
REQ-005 When en=1, sx SHALL increment by 1 per cycle. At H_END, sx SHALL wrap to H_STA and sy SHALL increment. When sy is at V_END and sx is at H_END, sy SHALL wrap to V_STA.
REQ-006 When en=0 and resync=0, sx, sy, fcnt and all decode outputs SHALL hold their values. line and frame SHALL be forced to 0 on held cycles, so a pulse is never stretched.
REQ-007 All outputs SHALL be registered. Decodes SHALL describe the sx/sy presented in the same cycle (zero relative latency), the reset state excepted.
REQ-008 hsync = H_POL when H_STA+H_FP <= sx < H_STA+H_FP+H_SYNC, else ~H_POL.
REQ-009 vsync = V_POL when V_STA+V_FP <= sy < V_STA+V_FP+V_SYNC, else ~V_POL.
REQ-010 de = 1 if and only if sx >= 0 and sy >= 0.
REQ-011 line = 1 on the cycle sx becomes H_STA. frame = 1 on the cycle sx becomes H_STA and sy becomes V_STA, and line is also 1 on that cycle.
REQ-012 fcnt SHALL increment, modulo 2^FCW, on every cycle where frame=1. It SHALL wrap from all-ones to 0 silently.
REQ-013 resync=1, sampled on any clock edge, SHALL load sx=H_STA and sy=V_STA on that edge and assert line=1 and frame=1, regardless of en.
REQ-014 resync while the counters would naturally wrap to frame start SHALL produce exactly one frame pulse and one fcnt increment.
REQ-015 Back-to-back resync SHALL restart on every asserted cycle, with one frame pulse per restart.

Reset
REQ-016 While rst_n=0, the block SHALL hold: sx=H_END, sy=V_END, hsync=~H_POL, vsync=~V_POL, de=0, line=0, frame=0, fcnt=all-ones.
REQ-017 Reset SHALL take effect immediately, including mid-line and mid-frame.
REQ-018 The first enabled cycle after release SHALL wrap to (H_STA,V_STA) with line=1, frame=1 and fcnt=0.
REQ-019 If en=0 after release, the reset state SHALL persist, with de=0, until the first enabled cycle.

Verification
Bench parameters: H_RES=8, H_FP=2, H_SYNC=2, H_BP=2, V_RES=4, V_FP=1, V_SYNC=1, V_BP=1, H_POL=0, V_POL=0, FCW=2. This gives H_STA=-6, V_STA=-3, and 98 cycles per frame.
REQ-020 Release reset with en=1 -> first cycle shows sx=-6, sy=-3, frame=1, fcnt=0. The next frame pulse arrives 98 cycles later with fcnt=1.
REQ-021 Sweep one full frame -> hsync=0 only at sx in {-4,-3}; vsync=0 only at sy=-2; de=1 for exactly 32 cycles; line=1 for exactly 7 cycles.
REQ-022 Run 4 frames -> fcnt sequence 0,1,2,3, then 0 on the 5th frame; no other fcnt changes occur.
REQ-023 Drop en for 5 cycles at sx=2, sy=1 -> sx, sy, de and hsync frozen; no line or frame pulse; resume continues from sx=3.
REQ-024 Pulse resync at sx=5, sy=2 with en=0 -> next cycle sx=-6, sy=-3, frame=1, fcnt incremented. Resync at sx=7, sy=3 -> single frame pulse.
REQ-025 Assert rst_n=0 mid-frame at sx=4, sy=0 -> outputs reach REQ-016 values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/display_timing_gen.sv
// Display timing generator: free-running raster counters with registered
// sync, data-enable, line/frame pulses and a frame counter. Position and
// decodes are computed together from the next position, so every output
// describes the same pixel in the cycle it is presented.
module display_timing_gen #(
  parameter int   CORDW  = 12,
  parameter int   H_RES  = 1024,
  parameter int   H_FP   = 160,
  parameter int   H_SYNC = 20,
  parameter int   H_BP   = 140,
  parameter int   V_RES  = 600,
  parameter int   V_FP   = 12,
  parameter int   V_SYNC = 3,
  parameter int   V_BP   = 20,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0,
  parameter int   FCW    = 8
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    resync,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    line,
  output logic                    frame,
  output logic [FCW-1:0]          fcnt
);

  localparam int H_STA_I = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA_I = -(V_FP + V_SYNC + V_BP);
  localparam int CMIN    = -(2 ** (CORDW - 1));
  localparam int CMAX    = (2 ** (CORDW - 1)) - 1;

  // Refuse to build when the blanking interval or active area does not fit
  // the signed coordinate width.
  if (H_STA_I < CMIN || V_STA_I < CMIN || H_RES - 1 > CMAX || V_RES - 1 > CMAX) begin : g_bad_cordw
    $error("display_timing_gen: timing does not fit in CORDW signed bits");
  end

  localparam logic signed [CORDW-1:0] H_STA  = CORDW'(H_STA_I);
  localparam logic signed [CORDW-1:0] H_END  = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] V_STA  = CORDW'(V_STA_I);
  localparam logic signed [CORDW-1:0] V_END  = CORDW'(V_RES - 1);
  localparam logic signed [CORDW-1:0] HS_BEG = CORDW'(H_STA_I + H_FP);
  localparam logic signed [CORDW-1:0] HS_END = CORDW'(H_STA_I + H_FP + H_SYNC);
  localparam logic signed [CORDW-1:0] VS_BEG = CORDW'(V_STA_I + V_FP);
  localparam logic signed [CORDW-1:0] VS_END = CORDW'(V_STA_I + V_FP + V_SYNC);

  logic signed [CORDW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic                    hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic                    line_q, line_d, frame_q, frame_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;

  // Next position, pulses and decodes; held cycles keep the decode registers
  // as they are so the reset state (de=0 at H_END/V_END) survives until the
  // first advance.
  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    fcnt_d  = fcnt_q;

    if (resync) begin
      sx_d    = H_STA;
      sy_d    = V_STA;
      line_d  = 1'b1;
      frame_d = 1'b1;
    end else if (en) begin
      if (sx_q == H_END) begin
        sx_d   = H_STA;
        line_d = 1'b1;
        if (sy_q == V_END) begin
          sy_d    = V_STA;
          frame_d = 1'b1;
        end else begin
          sy_d = sy_q + CORDW'(1);
        end
      end else begin
        sx_d = sx_q + CORDW'(1);
      end
    end

    if (resync || en) begin
      hsync_d = (sx_d >= HS_BEG && sx_d < HS_END) ? H_POL : ~H_POL;
      vsync_d = (sy_d >= VS_BEG && sy_d < VS_END) ? V_POL : ~V_POL;
      de_d    = !sx_d[CORDW-1] && !sy_d[CORDW-1];
    end

    // A resync landing on a natural wrap still yields a single frame pulse,
    // so one increment per pulse is enough.
    if (frame_d) begin
      fcnt_d = fcnt_q + FCW'(1);
    end
  end

  // Output registers with asynchronous reset to the pre-frame state.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= H_END;
      sy_q    <= V_END;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fcnt_q  <= '1;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign line  = line_q;
  assign frame = frame_q;
  assign fcnt  = fcnt_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen with a small raster. The reference model tracks
// only a pixel index within the frame and derives position and decodes
// arithmetically from the timing rules.
module tb_display_timing_gen;

  localparam int CORDW = 12;
  localparam int FCW   = 2;
  localparam int H_TOT = 14;
  localparam int F_TOT = 98;
  localparam int H_STA = -6;
  localparam int V_STA = -3;

  logic                    clk_pix = 1'b0;
  logic                    rst_n   = 1'b0;
  logic                    en      = 1'b0;
  logic                    resync  = 1'b0;
  logic signed [CORDW-1:0] sx, sy;
  logic                    hsync, vsync, de, line, frame;
  logic [FCW-1:0]          fcnt;

  display_timing_gen #(
    .CORDW(CORDW), .H_RES(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .FCW(FCW)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .en(en), .resync(resync),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de),
    .line(line), .frame(frame), .fcnt(fcnt)
  );

  always #5 clk_pix = ~clk_pix;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit in_reset = 1'b1;
  int p        = 0;
  int fc       = 3;
  bit line_e   = 1'b0;
  bit frame_e  = 1'b0;

  function automatic int mx();
    return in_reset ? 7 : H_STA + (p % H_TOT);
  endfunction
  function automatic int my();
    return in_reset ? 3 : V_STA + (p / H_TOT);
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    int x, y;
    x = mx();
    y = my();
    $display("%s: sx=%0d sy=%0d hs=%0b vs=%0b de=%0b line=%0b frame=%0b fcnt=%0d",
             tag, sx, sy, hsync, vsync, de, line, frame, fcnt);
    chk({tag, ".sx"}, sx, x);
    chk({tag, ".sy"}, sy, y);
    chk({tag, ".hsync"}, hsync, (!in_reset && x >= H_STA + 2 && x < H_STA + 4) ? 0 : 1);
    chk({tag, ".vsync"}, vsync, (!in_reset && y >= V_STA + 1 && y < V_STA + 2) ? 0 : 1);
    chk({tag, ".de"}, de, (!in_reset && x >= 0 && y >= 0) ? 1 : 0);
    chk({tag, ".line"}, line, line_e);
    chk({tag, ".frame"}, frame, frame_e);
    chk({tag, ".fcnt"}, fcnt, fc);
  endtask

  task automatic model_step(bit e, bit r);
    if (r) begin
      p = 0; in_reset = 1'b0; line_e = 1'b1; frame_e = 1'b1;
      fc = (fc + 1) % 4;
    end else if (e) begin
      p = in_reset ? 0 : (p + 1) % F_TOT;
      in_reset = 1'b0;
      line_e  = (p % H_TOT) == 0;
      frame_e = (p == 0);
      if (frame_e) fc = (fc + 1) % 4;
    end else begin
      line_e = 1'b0; frame_e = 1'b0;
    end
  endtask

  task automatic step(bit e, bit r, string tag);
    en = e;
    resync = r;
    @(posedge clk_pix);
    #1;
    model_step(e, r);
    check_all(tag);
  endtask

  task automatic advance_to(int x, int y, string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * F_TOT; i++) begin
      if (!in_reset && mx() == x && my() == y) begin
        hit = 1'b1;
        break;
      end
      step(1'b1, 1'b0, tag);
    end
    chk({tag, ".reached"}, hit, 1);
  endtask

  int de_cnt, line_cnt, hs_low, vs_low;

  initial begin
    // reset state
    repeat (3) @(posedge clk_pix);
    #1;
    check_all("reset");

    // release with en low: reset state persists
    @(negedge clk_pix);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "hold_after_rst");

    // first enabled cycle: frame start, fcnt=0
    step(1'b1, 1'b0, "first_frame");
    chk("first.frame", frame, 1);
    chk("first.fcnt", fcnt, 0);

    // sweep one frame, collecting statistics
    de_cnt = 0; line_cnt = 0; hs_low = 0; vs_low = 0;
    for (int i = 0; i < F_TOT; i++) begin
      de_cnt   += int'(de);
      line_cnt += int'(line);
      hs_low   += int'(!hsync);
      vs_low   += int'(!vsync);
      if (i < F_TOT - 1) step(1'b1, 1'b0, "sweep");
    end
    chk("sweep.de_count", de_cnt, 32);
    chk("sweep.line_count", line_cnt, 7);
    chk("sweep.hs_low_count", hs_low, 14);
    chk("sweep.vs_low_count", vs_low, 14);
    step(1'b1, 1'b0, "second_frame");
    chk("second.frame", frame, 1);
    chk("second.fcnt", fcnt, 1);

    // three more frames to wrap fcnt back to 0
    for (int i = 0; i < 3 * F_TOT; i++) step(1'b1, 1'b0, "frames");
    chk("wrap.fcnt", fcnt, 0);

    // freeze at (2,1) for 5 cycles, resume at 3
    advance_to(2, 1, "to_2_1");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "frozen");
    step(1'b1, 1'b0, "resume");
    chk("resume.sx", sx, 3);

    // resync with en low at (5,2)
    advance_to(5, 2, "to_5_2");
    step(1'b0, 1'b1, "resync_en0");
    chk("resync.sx", sx, -6);
    chk("resync.frame", frame, 1);

    // resync coinciding with the natural wrap, then back-to-back resync
    advance_to(7, 3, "to_7_3");
    step(1'b1, 1'b1, "resync_wrap");
    step(1'b1, 1'b0, "after_wrap");
    chk("after_wrap.frame", frame, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "resync_b2b");

    // randomized traffic
    for (int i = 0; i < 700; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0, "rand");

    // asynchronous reset mid-frame
    advance_to(4, 0, "to_4_0");
    #2;
    rst_n = 1'b0;
    #1;
    in_reset = 1'b1; p = 0; fc = 3; line_e = 1'b0; frame_e = 1'b0;
    check_all("async_rst");
    repeat (2) @(posedge clk_pix);
    @(negedge clk_pix);
    rst_n = 1'b1;
    step(1'b1, 1'b0, "rst_restart");
    chk("restart.fcnt", fcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
